// File: rtl/sprite_bitmap_loader_if.sv
// Pixel stream handshake between a bitmap source and the sprite loader.
// The master drives valid/data and the slave answers with ready.
interface sprite_bitmap_loader_if;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;

    modport master (output s_valid, output s_data, input  s_ready);
    modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

// File: rtl/sprite_bitmap_loader.sv
// Sprite bitmap writer with per-slot double buffering.
// A row-major pixel stream fills the shadow bank of the selected slot. The
// renderer reads the active bank through a one-cycle registered port. Banks
// swap only on frame_start, so a sprite never changes in the middle of a frame.
module sprite_bitmap_loader #(
    parameter int         SIZE_BITS            = 5,
    parameter int         NUM_SLOTS            = 2,
    parameter logic [7:0] TRANSPARENT_ENCODING = 8'h00,
    localparam int        SLOT_W               = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_resetN,
    input  logic                   i_start,
    input  logic [SLOT_W-1:0]      i_slot,
    sprite_bitmap_loader_if.slave  s_pix,
    input  logic                   i_frame_start,
    input  logic [SLOT_W-1:0]      i_rd_slot,
    input  logic [10:0]            i_offsetX,
    input  logic [10:0]            i_offsetY,
    output logic [7:0]             o_rd_data,
    output logic                   o_busy,
    output logic                   o_pending,
    output logic                   o_done,
    output logic [2*SIZE_BITS:0]   o_opaque_count
);

    localparam int AW    = 2 * SIZE_BITS;
    localparam int OW    = 2 * SIZE_BITS + 1;
    localparam int IDX_W = SLOT_W + 1 + AW;
    localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_SWAP = 2'd2
    } state_t;

    function automatic logic f_is_opaque(input logic [7:0] d);
        return d != TRANSPARENT_ENCODING;
    endfunction

    // Storage index is {slot, bank, y, x}
    logic [7:0]              r_mem [0:(2**IDX_W)-1];

    state_t                  r_state;
    state_t                  w_next_state;
    logic [(2**SLOT_W)-1:0]  r_active;
    logic [SLOT_W-1:0]       r_slot;
    logic [AW-1:0]           r_addr;
    logic [OW-1:0]           r_opaque;
    logic                    r_done;
    logic [7:0]              r_rd_data;

    logic                    w_start_acc;
    logic                    w_accept;
    logic                    w_swap;
    logic [IDX_W-1:0]        w_wr_idx;
    logic [IDX_W-1:0]        w_rd_idx;
    logic                    w_unused_offs;

    // The loader always writes the bank the renderer is not looking at
    assign w_wr_idx = {r_slot, ~r_active[r_slot], r_addr};
    assign w_rd_idx = {i_rd_slot, r_active[i_rd_slot],
                       i_offsetY[SIZE_BITS-1:0], i_offsetX[SIZE_BITS-1:0]};

    // Only the low offset bits address a sprite; the rest is screen position
    assign w_unused_offs = ^{i_offsetX[10:SIZE_BITS], i_offsetY[10:SIZE_BITS]};

    assign s_pix.s_ready  = (r_state == LOAD);
    assign o_busy         = (r_state != IDLE);
    assign o_pending      = (r_state == WAIT_SWAP);
    assign o_done         = r_done;
    assign o_opaque_count = r_opaque;
    assign o_rd_data      = r_rd_data;

    // Next-state decode and per-cycle strobes
    always_comb begin
        w_next_state = r_state;
        w_start_acc  = 1'b0;
        w_accept     = 1'b0;
        w_swap       = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_start_acc  = 1'b1;
                    w_next_state = LOAD;
                end
            end
            LOAD: begin
                if (s_pix.s_valid) begin
                    w_accept = 1'b1;
                    if (r_addr == LAST_ADDR) begin
                        w_next_state = WAIT_SWAP;
                    end
                end
            end
            WAIT_SWAP: begin
                if (i_frame_start) begin
                    w_swap       = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Control state: FSM, active bank per slot, done pulse, opaque counter
    always_ff @(posedge i_clk) begin
        if (i_resetN) begin
            r_state  <= IDLE;
            r_active <= '0;
            r_done   <= 1'b0;
            r_opaque <= '0;
        end else begin
            r_state <= w_next_state;
            r_done  <= w_swap;
            if (w_swap) begin
                r_active[r_slot] <= ~r_active[r_slot];
            end
            if (w_start_acc) begin
                r_opaque <= '0;
            end else if (w_accept && f_is_opaque(s_pix.s_data)) begin
                r_opaque <= r_opaque + OW'(1);
            end
        end
    end

    // Load target and write address; cleared by start, so no reset needed
    always_ff @(posedge i_clk) begin
        if (w_start_acc) begin
            r_slot <= i_slot;
            r_addr <= '0;
        end else if (w_accept) begin
            r_addr <= r_addr + AW'(1);
        end
    end

    // Shadow-bank write port
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_mem[w_wr_idx] <= s_pix.s_data;
        end
    end

    // Registered renderer read from the active bank
    always_ff @(posedge i_clk) begin
        if (i_resetN) begin
            r_rd_data <= 8'h00;
        end else begin
            r_rd_data <= r_mem[w_rd_idx];
        end
    end

endmodule

// File: tb/tb_sprite_bitmap_loader.sv
// Scoreboard bench for sprite_bitmap_loader: a reference model of the two
// banks per slot predicts every read and every done pulse; a monitor pops
// the predictions whenever the DUT presents rd_data or done.
module tb_sprite_bitmap_loader;
    localparam int NPIX = 1024;

    logic        clk = 1'b0;
    logic        resetN, start, slot_i, frame_start, rd_slot;
    logic [10:0] offX, offY;
    logic [7:0]  rd_data;
    logic        busy, pending, done;
    logic [10:0] opaque;

    always #5 clk = ~clk;

    sprite_bitmap_loader_if pix_if ();

    sprite_bitmap_loader dut (
        .i_clk          (clk),
        .i_resetN       (resetN),
        .i_start        (start),
        .i_slot         (slot_i),
        .s_pix          (pix_if),
        .i_frame_start  (frame_start),
        .i_rd_slot      (rd_slot),
        .i_offsetX      (offX),
        .i_offsetY      (offY),
        .o_rd_data      (rd_data),
        .o_busy         (busy),
        .o_pending      (pending),
        .o_done         (done),
        .o_opaque_count (opaque)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: contents of every bank, active bank per slot, load status
    logic [7:0] ref_mem [2][2][NPIX];
    bit         ref_active [2];
    bit         ref_wait;
    int         ref_slot;
    int         ref_opaque;

    logic [7:0] pix [NPIX];
    int         exp_done_q[$];
    int         exp_rd_q[$];
    logic       rd_req = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event with no matching expectation", name);
    endtask

    // Monitor: compare rd_data one cycle after a read and opaque_count on done
    initial begin
        logic s_rd;
        forever begin
            @(posedge clk);
            s_rd = rd_req;
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_done_q.size() == 0) fail_evt("unexpected_done");
                else chk("done_opaque", 32'(opaque), 32'(exp_done_q.pop_front()));
            end
            if (s_rd) begin
                if (exp_rd_q.size() == 0) fail_evt("rd_underflow");
                else chk("rd_data", 32'(rd_data), 32'(exp_rd_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_read(input int s, input int x, input int y);
        rd_slot = s[0];
        offX    = 11'(($urandom_range(0, 63) << 5) | x);
        offY    = 11'(($urandom_range(0, 63) << 5) | y);
        rd_req  = 1'b1;
        exp_rd_q.push_back(int'(ref_mem[s][ref_active[s]][y * 32 + x]));
    endtask

    task automatic rd(input int s, input int x, input int y);
        set_read(s, x, y);
        tick();
        rd_req = 1'b0;
    endtask

    // vmode: 0 = always valid, 1 = toggle every other cycle, 2 = random
    task automatic load(input int s, input int nmax, input int vmode,
                        input bit fs_on_last, input bit noise_start);
        int  addr;
        int  cyc;
        int  ready_cycles;
        bit  v;
        bit  r;
        start  = 1'b1;
        slot_i = s[0];
        tick();
        start      = 1'b0;
        ref_slot   = s;
        ref_opaque = 0;
        chk("ready_after_start", 32'(pix_if.s_ready), 32'd1);
        chk("busy_after_start", 32'(busy), 32'd1);
        addr = 0;
        cyc = 0;
        ready_cycles = 0;
        while (addr < nmax && cyc < 6000) begin
            v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            r = pix_if.s_ready;
            pix_if.s_valid = v;
            pix_if.s_data  = pix[addr];
            frame_start = fs_on_last && (addr == NPIX - 1) && v && r;
            start       = noise_start && ($urandom_range(0, 7) == 0);
            slot_i      = 1'($urandom_range(0, 1));
            if (r) ready_cycles++;
            tick();
            if (v && r) begin
                ref_mem[s][!ref_active[s]][addr] = pix[addr];
                if (pix[addr] != 8'h00) ref_opaque++;
                addr++;
            end
            cyc++;
        end
        if (cyc >= 6000) fail_evt("load_timeout");
        pix_if.s_valid = 1'b0;
        frame_start    = 1'b0;
        start          = 1'b0;
        if (nmax == NPIX) begin
            ref_wait = 1'b1;
            chk("ready_low_after_last", 32'(pix_if.s_ready), 32'd0);
            chk("pending_after_last", 32'(pending), 32'd1);
            chk("busy_after_last", 32'(busy), 32'd1);
            chk("opaque_after_last", 32'(opaque), 32'(ref_opaque));
            if (vmode == 0) chk("ready_cycles", 32'(ready_cycles), 32'(NPIX));
        end
    endtask

    task automatic swap(input bit with_read, input int rs, input int x, input int y);
        frame_start = 1'b1;
        if (ref_wait) exp_done_q.push_back(ref_opaque);
        if (with_read) set_read(rs, x, y);
        tick();
        frame_start = 1'b0;
        rd_req      = 1'b0;
        if (ref_wait) begin
            ref_active[ref_slot] = !ref_active[ref_slot];
            ref_wait = 1'b0;
        end
        chk("pending_after_swap", 32'(pending), 32'd0);
        chk("busy_after_swap", 32'(busy), 32'd0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < NPIX; i++) pix[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic random_reads(input int n);
        for (int i = 0; i < n; i++)
            rd($urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 31));
    endtask

    initial begin
        int cnt;
        resetN = 1'b1;
        start = 1'b0;
        slot_i = 1'b0;
        frame_start = 1'b0;
        rd_slot = 1'b0;
        offX = '0;
        offY = '0;
        pix_if.s_valid = 1'b0;
        pix_if.s_data  = 8'h00;
        ref_active[0] = 1'b0;
        ref_active[1] = 1'b0;
        ref_wait = 1'b0;
        ref_slot = 0;
        ref_opaque = 0;
        for (int s = 0; s < 2; s++)
            for (int b = 0; b < 2; b++)
                for (int a = 0; a < NPIX; a++) ref_mem[s][b][a] = 8'h00;
        repeat (3) tick();
        chk("rst_s_ready", 32'(pix_if.s_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_opaque", 32'(opaque), 32'd0);
        resetN = 1'b0;
        tick();

        // Preload every bank with zeros so all reads are defined
        for (int i = 0; i < NPIX; i++) pix[i] = 8'h00;
        for (int s = 0; s < 2; s++)
            for (int k = 0; k < 2; k++) begin
                load(s, NPIX, 0, 1'b0, 1'b0);
                swap(1'b0, 0, 0, 0);
            end

        // Solid 8'hE0 into slot 0; old bank visible until the swap
        for (int i = 0; i < NPIX; i++) pix[i] = 8'hE0;
        load(0, NPIX, 0, 1'b0, 1'b0);
        chk("opaque_1024", 32'(opaque), 32'd1024);
        rd(0, 5, 7);
        swap(1'b1, 0, 5, 7);
        rd(0, 5, 7);

        // Address ramp into slot 1 with toggling valid and stray starts
        for (int i = 0; i < NPIX; i++) pix[i] = 8'(i);
        load(1, NPIX, 1, 1'b0, 1'b1);
        start = 1'b1;
        slot_i = 1'b0;
        tick();
        start = 1'b0;
        chk("start_ignored_in_wait", 32'(pending), 32'd1);
        swap(1'b0, 0, 0, 0);
        rd(1, 3, 2);
        rd(0, 5, 7);
        random_reads(16);

        // frame_start while idle is not a swap event
        swap(1'b0, 0, 0, 0);

        // 100 transparent among 924 opaque, frame_start on the last pixel
        for (int i = 0; i < NPIX; i++) pix[i] = 8'h05;
        cnt = 0;
        while (cnt < 100) begin
            int j;
            j = $urandom_range(0, NPIX - 1);
            if (pix[j] != 8'h00) begin
                pix[j] = 8'h00;
                cnt++;
            end
        end
        load(0, NPIX, 2, 1'b1, 1'b0);
        chk("opaque_924", 32'(opaque), 32'd924);
        rd(0, 1, 1);
        swap(1'b0, 0, 0, 0);

        // start in the done cycle is accepted
        fill_random();
        load(1, NPIX, 2, 1'b0, 1'b1);
        swap(1'b1, 1, 9, 30);
        random_reads(24);

        // Make both slots show bank 1 so a reset visibly returns them to bank 0
        for (int s = 0; s < 2; s++)
            while (ref_active[s] == 1'b0) begin
                fill_random();
                load(s, NPIX, 2, 1'b0, 1'b0);
                swap(1'b0, 0, 0, 0);
            end
        random_reads(16);

        // Abandon a load after 500 pixels with reset
        fill_random();
        load(0, 500, 0, 1'b0, 1'b0);
        resetN = 1'b1;
        tick();
        resetN = 1'b0;
        ref_active[0] = 1'b0;
        ref_active[1] = 1'b0;
        ref_wait = 1'b0;
        chk("midload_rst_busy", 32'(busy), 32'd0);
        chk("midload_rst_ready", 32'(pix_if.s_ready), 32'd0);
        chk("midload_rst_rd_data", 32'(rd_data), 32'd0);
        chk("midload_rst_pending", 32'(pending), 32'd0);
        chk("midload_rst_opaque", 32'(opaque), 32'd0);
        random_reads(24);
        rd(0, 0, 0);
        rd(0, 31, 31);

        // Normal operation resumes after the reset
        fill_random();
        load(1, NPIX, 2, 1'b0, 1'b1);
        swap(1'b0, 0, 0, 0);
        random_reads(16);
        tick();
        tick();
        chk("done_queue_empty", 32'(exp_done_q.size()), 32'd0);
        chk("rd_queue_empty", 32'(exp_rd_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
